// File: rtl/vgen_pkg.sv
// Shared types for the video stream generator: FSM states and pixel pattern codes.
package vgen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PIX,
    LGAP,
    FGAP
  } state_e;

  typedef enum logic [1:0] {
    PAT_X,
    PAT_Y,
    PAT_CHECK,
    PAT_FRAME
  } pattern_e;

  localparam int unsigned FRAME_CNT_WIDTH = 8;

endpackage

// File: rtl/vgen_pattern.sv
// Combinational pixel value from position, frame count and pattern select.
// Pattern selection is built only with VGEN_PATTERN_SEL_EN; otherwise pixel = x+1.
module vgen_pattern
  import vgen_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic [CNT_WIDTH-1:0]       x_i,
  input  logic [CNT_WIDTH-1:0]       y_i,
  input  logic [FRAME_CNT_WIDTH-1:0] frame_i,
  input  pattern_e                   pattern_i,
  output logic [PIXEL_WIDTH-1:0]     pix_c_o
);

`ifdef VGEN_PATTERN_SEL_EN
  always_comb begin
    pix_c_o = PIXEL_WIDTH'(x_i + CNT_WIDTH'(1));
    case (pattern_i)
      PAT_X:     pix_c_o = PIXEL_WIDTH'(x_i + CNT_WIDTH'(1));
      PAT_Y:     pix_c_o = PIXEL_WIDTH'(y_i + CNT_WIDTH'(1));
      PAT_CHECK: pix_c_o = {PIXEL_WIDTH{x_i[3] ^ y_i[3]}};
      PAT_FRAME: pix_c_o = PIXEL_WIDTH'(frame_i);
      default:   pix_c_o = PIXEL_WIDTH'(x_i + CNT_WIDTH'(1));
    endcase
  end
`else
  assign pix_c_o = PIXEL_WIDTH'(x_i + CNT_WIDTH'(1));

  logic unused_in;
  assign unused_in = ^{y_i, frame_i, pattern_i};
`endif

endmodule

// File: rtl/video_stream_gen.sv
// Video stream source emitting de/hs/vs framed pixel data with configurable geometry and pacing.
// Optional macro VGEN_PATTERN_SEL_EN enables the pattern select input and frame counter.
module video_stream_gen
  import vgen_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [CNT_WIDTH-1:0]   line_size,
  input  logic [CNT_WIDTH-1:0]   frame_lines,
  input  logic [CNT_WIDTH-1:0]   pix_period,
  input  logic [CNT_WIDTH-1:0]   line_gap,
  input  logic [CNT_WIDTH-1:0]   frame_gap,
  input  logic [1:0]             pattern,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  state_e               state_q;
  logic [CNT_WIDTH-1:0] lsize_q, flines_q, period_q, lgap_q, fgap_q;
  logic [CNT_WIDTH-1:0] x_q, y_q, pcnt_q, gcnt_q;

  logic                       start_c, fgap_last_c, start_now_c, last_x_c, last_y_c;
  logic [PIXEL_WIDTH-1:0]     pix_c;
  logic [FRAME_CNT_WIDTH-1:0] frm_c;
  pattern_e                   pat_c;

`ifdef VGEN_PATTERN_SEL_EN
  pattern_e                   pat_q;
  logic [FRAME_CNT_WIDTH-1:0] frm_q;

  assign frm_c = frm_q;
  assign pat_c = pat_q;
`else
  assign frm_c = '0;
  assign pat_c = PAT_X;

  logic unused_pattern;
  assign unused_pattern = ^pattern;
`endif

  assign start_c     = en && (line_size != '0) && (frame_lines != '0);
  assign fgap_last_c = (fgap_q <= CNT_WIDTH'(1)) || (gcnt_q == fgap_q - CNT_WIDTH'(1));
  assign start_now_c = start_c && ((state_q == IDLE) || ((state_q == FGAP) && fgap_last_c));
  assign last_x_c    = (x_q == lsize_q - CNT_WIDTH'(1));
  assign last_y_c    = (y_q == flines_q - CNT_WIDTH'(1));

  vgen_pattern #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_pattern (
    .x_i       (x_q),
    .y_i       (y_q),
    .frame_i   (frm_c),
    .pattern_i (pat_c),
    .pix_c_o   (pix_c)
  );

  // FSM, counters and registered stream outputs; a frame start overrides the per-state updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lsize_q      <= '0;
      flines_q     <= '0;
      period_q     <= '0;
      lgap_q       <= '0;
      fgap_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pcnt_q       <= '0;
      gcnt_q       <= '0;
      do_o         <= '0;
      de_o         <= 1'b0;
      hs_o         <= 1'b0;
      vs_o         <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
`ifdef VGEN_PATTERN_SEL_EN
      pat_q        <= PAT_X;
      frm_q        <= '0;
`endif
    end else begin
      de_o         <= 1'b0;
      hs_o         <= 1'b0;
      vs_o         <= 1'b0;
      frame_done_o <= 1'b0;

      case (state_q)
        IDLE: busy_o <= 1'b0;

        PIX: begin
          if (pcnt_q == '0) begin
            de_o <= 1'b1;
            hs_o <= (x_q == '0);
            vs_o <= (x_q == '0) && (y_q == '0);
            do_o <= pix_c;
            if (last_x_c) begin
              x_q    <= '0;
              pcnt_q <= '0;
              gcnt_q <= '0;
              if (last_y_c) begin
                state_q <= FGAP;
              end else if (lgap_q == '0) begin
                y_q <= y_q + CNT_WIDTH'(1);
              end else begin
                state_q <= LGAP;
              end
            end else if (period_q <= CNT_WIDTH'(1)) begin
              x_q <= x_q + CNT_WIDTH'(1);
            end else begin
              pcnt_q <= CNT_WIDTH'(1);
            end
          end else if (pcnt_q == period_q - CNT_WIDTH'(1)) begin
            pcnt_q <= '0;
            x_q    <= x_q + CNT_WIDTH'(1);
          end else begin
            pcnt_q <= pcnt_q + CNT_WIDTH'(1);
          end
        end

        LGAP: begin
          if (gcnt_q == lgap_q - CNT_WIDTH'(1)) begin
            gcnt_q  <= '0;
            y_q     <= y_q + CNT_WIDTH'(1);
            state_q <= PIX;
          end else begin
            gcnt_q <= gcnt_q + CNT_WIDTH'(1);
          end
        end

        FGAP: begin
          if (fgap_last_c) begin
            frame_done_o <= 1'b1;
            state_q      <= IDLE;
`ifdef VGEN_PATTERN_SEL_EN
            frm_q        <= frm_q + FRAME_CNT_WIDTH'(1);
`endif
          end else begin
            gcnt_q <= gcnt_q + CNT_WIDTH'(1);
          end
        end

        default: state_q <= IDLE;
      endcase

      if (start_now_c) begin
        lsize_q  <= line_size;
        flines_q <= frame_lines;
        period_q <= pix_period;
        lgap_q   <= line_gap;
        fgap_q   <= frame_gap;
        x_q      <= '0;
        y_q      <= '0;
        pcnt_q   <= '0;
        gcnt_q   <= '0;
        busy_o   <= 1'b1;
        state_q  <= PIX;
`ifdef VGEN_PATTERN_SEL_EN
        pat_q    <= pattern_e'(pattern);
`endif
      end
    end
  end

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed self-checking bench for video_stream_gen: frame timing, pacing, reset, en handling, wrap.
module tb_video_stream_gen;

  typedef struct packed {
    int         t;
    logic [7:0] d;
    logic       hs;
    logic       vs;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] line_size, frame_lines, pix_period, line_gap, frame_gap;
  logic [1:0]  pattern;
  logic [7:0]  do_o;
  logic        de_o, hs_o, vs_o, busy_o, frame_done_o;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   stray = 0;
  int   busy_cnt = 0;
  pix_t pix_q[$];
  pix_t exp_q[$];
  int   done_q[$];

  video_stream_gen dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .line_size    (line_size),
    .frame_lines  (frame_lines),
    .pix_period   (pix_period),
    .line_gap     (line_gap),
    .frame_gap    (frame_gap),
    .pattern      (pattern),
    .do_o         (do_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture stream activity tagged with the number of rising edges seen so far.
  always @(negedge clk) begin
    if (de_o) pix_q.push_back('{t: cyc, d: do_o, hs: hs_o, vs: vs_o});
    if ((hs_o || vs_o) && !de_o) stray++;
    if (frame_done_o) done_q.push_back(cyc);
    if (busy_o) busy_cnt++;
  end

  task automatic set_cfg(input int ls, input int fl, input int per, input int lg, input int fg);
    line_size   = 16'(ls);
    frame_lines = 16'(fl);
    pix_period  = 16'(per);
    line_gap    = 16'(lg);
    frame_gap   = 16'(fg);
  endtask

  task automatic clear_logs();
    pix_q.delete();
    exp_q.delete();
    done_q.delete();
  endtask

  // Reference frame model: first pixel lands one edge after the start edge k.
  task automatic build_exp(input int k, input int ls, input int fl, input int per, input int lg,
                           input int dv, input int lim);
    int t = k + 1;
    int p = (per <= 1) ? 1 : per;
    int n = 0;
    for (int l = 0; l < fl; l++) begin
      for (int x = 0; x < ls; x++) begin
        pix_t e;
        e.t  = t;
        e.d  = (dv < 0) ? 8'((x + 1) % 256) : 8'(dv);
        e.hs = (x == 0);
        e.vs = (x == 0) && (l == 0);
        if (n < lim) exp_q.push_back(e);
        n++;
        t += (x == ls - 1) ? 1 + lg : p;
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (do_o !== 8'd0) begin n_fail++; $display("FAIL rst_do: got %0d expected 0", do_o); end
    n_checks++;
    if (de_o !== 1'b0) begin n_fail++; $display("FAIL rst_de: got %b expected 0", de_o); end
    n_checks++;
    if (hs_o !== 1'b0) begin n_fail++; $display("FAIL rst_hs: got %b expected 0", hs_o); end
    n_checks++;
    if (vs_o !== 1'b0) begin n_fail++; $display("FAIL rst_vs: got %b expected 0", vs_o); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    n_checks++;
    if (frame_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", frame_done_o); end
  endtask

  task automatic test_basic_frame();
    int k;
    pix_t g;
    clear_logs();
    set_cfg(4, 3, 0, 2, 5);
    en = 1'b1;
    k  = cyc + 1;
    build_exp(k, 4, 3, 0, 2, -1, 1000);
    @(negedge clk);
    en = 1'b0;
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start: got %b expected 1", busy_o); end
    n_checks++;
    if (de_o !== 1'b0) begin n_fail++; $display("FAIL basic_no_de_at_latch: got %b expected 0", de_o); end
    repeat (21) @(negedge clk);
    n_checks++;
    if (frame_done_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_done_pulse: got done=%b busy=%b expected 1 1", frame_done_o, busy_o);
    end
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy_o); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (pix_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL basic_pix_count: got %0d expected %0d", pix_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < pix_q.size()) ? pix_q[i] : '0;
      n_checks++;
      if (g !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_pix[%0d]: got t=%0d d=%0d hs=%b vs=%b expected t=%0d d=%0d hs=%b vs=%b",
                 i, g.t, g.d, g.hs, g.vs, exp_q[i].t, exp_q[i].d, exp_q[i].hs, exp_q[i].vs);
      end
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != k + 21) begin
      n_fail++; $display("FAIL basic_done_time: got n=%0d t=%0d expected n=1 t=%0d",
                         done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, k + 21);
    end
  endtask

  task automatic test_pix_period();
    int k;
    pix_t g;
    clear_logs();
    stray = 0;
    set_cfg(4, 3, 4, 2, 5);
    en = 1'b1;
    k  = cyc + 1;
    build_exp(k, 4, 3, 4, 2, -1, 1000);
    @(negedge clk);
    en = 1'b0;
    repeat (48) @(negedge clk);
    n_checks++;
    if (frame_done_o !== 1'b1) begin n_fail++; $display("FAIL period_done_pulse: got %b expected 1", frame_done_o); end
    @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL period_busy_end: got %b expected 0", busy_o); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (pix_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL period_pix_count: got %0d expected %0d", pix_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < pix_q.size()) ? pix_q[i] : '0;
      n_checks++;
      if (g !== exp_q[i]) begin
        n_fail++;
        $display("FAIL period_pix[%0d]: got t=%0d d=%0d hs=%b vs=%b expected t=%0d d=%0d hs=%b vs=%b",
                 i, g.t, g.d, g.hs, g.vs, exp_q[i].t, exp_q[i].d, exp_q[i].hs, exp_q[i].vs);
      end
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL period_sync_without_de: got %0d expected 0", stray); end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != k + 48) begin
      n_fail++; $display("FAIL period_done_time: got n=%0d t=%0d expected n=1 t=%0d",
                         done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, k + 48);
    end
  endtask

  task automatic test_reset_mid_frame();
    int k, k2;
    pix_t g;
    clear_logs();
    set_cfg(4, 3, 0, 2, 5);
    en = 1'b1;
    k  = cyc + 1;
    build_exp(k, 4, 3, 0, 2, -1, 6);
    @(negedge clk);
    en = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({do_o, de_o, hs_o, vs_o, busy_o, frame_done_o} !== 13'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got do=%0d de=%b hs=%b vs=%b busy=%b done=%b expected all 0",
                         do_o, de_o, hs_o, vs_o, busy_o, frame_done_o);
    end
    rst = 1'b0;
    en  = 1'b1;
    k2  = cyc + 1;
    build_exp(k2, 4, 3, 0, 2, -1, 1000);
    @(negedge clk);
    en = 1'b0;
    repeat (25) @(negedge clk);
    n_checks++;
    if (pix_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midrst_pix_count: got %0d expected %0d", pix_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < pix_q.size()) ? pix_q[i] : '0;
      n_checks++;
      if (g !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_pix[%0d]: got t=%0d d=%0d hs=%b vs=%b expected t=%0d d=%0d hs=%b vs=%b",
                 i, g.t, g.d, g.hs, g.vs, exp_q[i].t, exp_q[i].d, exp_q[i].hs, exp_q[i].vs);
      end
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != k2 + 21) begin
      n_fail++; $display("FAIL midrst_done_time: got n=%0d t=%0d expected n=1 t=%0d",
                         done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, k2 + 21);
    end
  endtask

  task automatic test_en_drop();
    int k;
    pix_t g;
    clear_logs();
    set_cfg(4, 3, 0, 2, 5);
    en = 1'b1;
    k  = cyc + 1;
    build_exp(k, 4, 3, 0, 2, -1, 1000);
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL endrop_busy_idle: got %b expected 0", busy_o); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (pix_q.size() != 12 || done_q.size() != 1 || done_q[0] != k + 21) begin
      n_fail++; $display("FAIL endrop_full_frame: got pix=%0d done_n=%0d expected pix=12 done_n=1 at %0d",
                         pix_q.size(), done_q.size(), k + 21);
    end

    clear_logs();
    en = 1'b1;
    k  = cyc + 1;
    build_exp(k, 4, 3, 0, 2, -1, 1000);
    build_exp(k + 21, 4, 3, 0, 2, -1, 1000);
    @(negedge clk);
    repeat (22) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_held: got %b expected 1", busy_o); end
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (18) @(negedge clk);
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b expected 0", busy_o); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (pix_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_pix_count: got %0d expected %0d", pix_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < pix_q.size()) ? pix_q[i] : '0;
      n_checks++;
      if (g !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_pix[%0d]: got t=%0d d=%0d hs=%b vs=%b expected t=%0d d=%0d hs=%b vs=%b",
                 i, g.t, g.d, g.hs, g.vs, exp_q[i].t, exp_q[i].d, exp_q[i].hs, exp_q[i].vs);
      end
    end
    n_checks++;
    if (done_q.size() != 2 || done_q[0] != k + 21 || done_q[1] != k + 42) begin
      n_fail++; $display("FAIL b2b_done_times: got n=%0d expected n=2 at %0d and %0d",
                         done_q.size(), k + 21, k + 42);
    end
  endtask

  task automatic test_wrap_and_zero();
    int k;
    pix_t g;
    clear_logs();
    set_cfg(300, 2, 0, 0, 0);
    en = 1'b1;
    k  = cyc + 1;
    build_exp(k, 300, 2, 0, 0, -1, 1000);
    @(negedge clk);
    en = 1'b0;
    repeat (601) @(negedge clk);
    n_checks++;
    if (frame_done_o !== 1'b1) begin n_fail++; $display("FAIL wrap_done_after_last: got %b expected 1", frame_done_o); end
    repeat (5) @(negedge clk);
    n_checks++;
    if (pix_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wrap_pix_count: got %0d expected %0d", pix_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < pix_q.size()) ? pix_q[i] : '0;
      n_checks++;
      if (g !== exp_q[i]) begin
        n_fail++;
        $display("FAIL wrap_pix[%0d]: got t=%0d d=%0d hs=%b vs=%b expected t=%0d d=%0d hs=%b vs=%b",
                 i, g.t, g.d, g.hs, g.vs, exp_q[i].t, exp_q[i].d, exp_q[i].hs, exp_q[i].vs);
      end
    end
    n_checks++;
    if (pix_q.size() > 255 && pix_q[255].d !== 8'd0) begin
      n_fail++; $display("FAIL wrap_x255: got %0d expected 0", pix_q[255].d);
    end

    clear_logs();
    busy_cnt = 0;
    set_cfg(0, 3, 0, 2, 5);
    en = 1'b1;
    repeat (20) @(negedge clk);
    set_cfg(4, 0, 0, 2, 5);
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_cnt != 0) begin n_fail++; $display("FAIL zero_size_busy: got %0d busy cycles expected 0", busy_cnt); end
    n_checks++;
    if (pix_q.size() != 0 || done_q.size() != 0) begin
      n_fail++; $display("FAIL zero_size_output: got pix=%0d done=%0d expected 0 0", pix_q.size(), done_q.size());
    end
  endtask

`ifdef VGEN_PATTERN_SEL_EN
  task automatic test_pattern();
    int k;
    pix_t g;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    set_cfg(4, 3, 0, 2, 5);
    pattern = 2'd3;
    en = 1'b1;
    k  = cyc + 1;
    build_exp(k, 4, 3, 0, 2, 0, 1000);
    build_exp(k + 21, 4, 3, 0, 2, 1, 1000);
    build_exp(k + 42, 4, 3, 0, 2, 2, 1000);
    build_exp(k + 63, 4, 3, 0, 2, -1, 1000);
    @(negedge clk);
    repeat (45) @(negedge clk);
    pattern = 2'd0;
    repeat (18) @(negedge clk);
    en = 1'b0;
    repeat (26) @(negedge clk);
    n_checks++;
    if (pix_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL pat_pix_count: got %0d expected %0d", pix_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < pix_q.size()) ? pix_q[i] : '0;
      n_checks++;
      if (g !== exp_q[i]) begin
        n_fail++;
        $display("FAIL pat_pix[%0d]: got t=%0d d=%0d hs=%b vs=%b expected t=%0d d=%0d hs=%b vs=%b",
                 i, g.t, g.d, g.hs, g.vs, exp_q[i].t, exp_q[i].d, exp_q[i].hs, exp_q[i].vs);
      end
    end
    n_checks++;
    if (done_q.size() != 4) begin n_fail++; $display("FAIL pat_done_count: got %0d expected 4", done_q.size()); end
  endtask
`else
  task automatic test_pattern();
    int k;
    pix_t g;
    clear_logs();
    set_cfg(4, 3, 0, 2, 5);
    pattern = 2'd3;
    en = 1'b1;
    k  = cyc + 1;
    build_exp(k, 4, 3, 0, 2, -1, 1000);
    @(negedge clk);
    en = 1'b0;
    repeat (26) @(negedge clk);
    pattern = 2'd0;
    n_checks++;
    if (pix_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL patoff_pix_count: got %0d expected %0d", pix_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      g = (i < pix_q.size()) ? pix_q[i] : '0;
      n_checks++;
      if (g !== exp_q[i]) begin
        n_fail++;
        $display("FAIL patoff_pix[%0d]: got t=%0d d=%0d expected t=%0d d=%0d",
                 i, g.t, g.d, exp_q[i].t, exp_q[i].d);
      end
    end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    pattern = 2'd0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_basic_frame();
    test_pix_period();
    test_reset_mid_frame();
    test_en_drop();
    test_wrap_and_zero();
    test_pattern();
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL sync_without_de_total: got %0d expected 0", stray); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
